switch_input_sampler: RTL

Upstream conditioning stage for `Neural_net_controller`. It takes the four raw board switches that encode the mine-sensor pattern and synchronises each one into the clock domain. Each switch is debounced independently. The stable 4-bit pattern drives the controller's `switch_1..switch_4` inputs, and every committed pattern change is announced to the result-capture logic through a valid/ack handshake and a wrap-around change counter.

---
 rtl/nn_io_pkg.sv | 12 +
 rtl/switch_input_sampler_if.sv | 37 +++
 rtl/switch_debouncer.sv | 53 +++++
 rtl/switch_input_sampler.sv | 73 +++++++
 4 files changed

// File: rtl/nn_io_pkg.sv
// Shared definitions for the switch conditioning path feeding the neural-net controller.
// Switch vectors are ordered bit 3 = switch 1 down to bit 0 = switch 4.
package nn_io_pkg;

    localparam int SW_W             = 4;
    localparam int DEBOUNCE_DEFAULT = 250000;
    localparam int CHG_CNT_W        = 8;

    typedef logic [SW_W-1:0]      sw_vec_t;
    typedef logic [CHG_CNT_W-1:0] chg_cnt_t;

endpackage

// File: rtl/switch_input_sampler_if.sv
// Bundle between the raw switches, the sampler and the result-capture logic.
// The master side is the sampler; the slave side drives switches and ack.
interface switch_input_sampler_if;
    import nn_io_pkg::*;

    sw_vec_t  sw_raw;
    logic     switch_1;
    logic     switch_2;
    logic     switch_3;
    logic     switch_4;
    logic     pattern_valid;
    logic     pattern_ack;
    chg_cnt_t change_count;

    modport master (
        input  sw_raw,
        input  pattern_ack,
        output switch_1,
        output switch_2,
        output switch_3,
        output switch_4,
        output pattern_valid,
        output change_count
    );

    modport slave (
        output sw_raw,
        output pattern_ack,
        input  switch_1,
        input  switch_2,
        input  switch_3,
        input  switch_4,
        input  pattern_valid,
        input  change_count
    );

endinterface

// File: rtl/switch_debouncer.sv
// One switch bit: two-flop synchroniser, run-length counter and stable-value flop.
// stable_next is the value the stable flop takes on the coming edge.
module switch_debouncer
    import nn_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable_next
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             d_q;
    logic             d_d;
    logic [CNT_W-1:0] c_q;
    logic [CNT_W-1:0] c_d;

    // Any sample matching the stable value restarts the run, so short glitches never land.
    always_comb begin
        d_d = d_q;
        c_d = '0;
        if (sync2_q != d_q) begin
            if (c_q == C_LAST) begin
                d_d = sync2_q;
            end else begin
                c_d = c_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            d_q     <= 1'b0;
            c_q     <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            d_q     <= d_d;
            c_q     <= c_d;
        end
    end

    assign stable_next = d_d;

endmodule

// File: rtl/switch_input_sampler.sv
// Debounces the four sensor-pattern switches and publishes each committed pattern
// change with a valid/ack handshake and a wrap-around change counter.
module switch_input_sampler
    import nn_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    switch_input_sampler_if.master bus
);

    sw_vec_t  stable_next;
    sw_vec_t  sw_q;
    sw_vec_t  sw_d;
    logic     valid_q;
    logic     valid_d;
    chg_cnt_t cnt_q;
    chg_cnt_t cnt_d;
    logic     commit;

    genvar gi;
    generate
        for (gi = 0; gi < SW_W; gi++) begin : g_bit
            switch_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debouncer (
                .clk         (clk),
                .rst_n       (rst_n),
                .raw         (bus.sw_raw[gi]),
                .stable_next (stable_next[gi])
            );
        end
    endgenerate

    // Comparing against the debouncers' next stable vector lets the outputs move on
    // the same edge the debouncers accept, while staying purely registered.
    always_comb begin
        commit  = (stable_next != sw_q);
        sw_d    = sw_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (commit) begin
            sw_d    = stable_next;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CHG_CNT_W'(1);
        end else if (bus.pattern_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sw_q    <= sw_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.switch_1      = sw_q[3];
    assign bus.switch_2      = sw_q[2];
    assign bus.switch_3      = sw_q[1];
    assign bus.switch_4      = sw_q[0];
    assign bus.pattern_valid = valid_q;
    assign bus.change_count  = cnt_q;

endmodule
